// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU operation sequencer and its result FIFO.
package alu_op_sequencer_pkg;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_GT   = 3'b010;
  localparam logic [2:0] OP_LT   = 3'b011;

  typedef enum logic {
    StIdle,
    StExec
  } state_e;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  tag;
    logic        err;
  } fifo_entry_t;

  function automatic logic op_supported(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_GT) || (op == OP_LT);
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Result FIFO with occupancy counter; the head entry is presented combinationally.
module alu_result_fifo #(
  parameter int unsigned Depth = 4,
  parameter type entry_t = logic [36:0]
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   empty,
  output logic   full
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  entry_t            mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop cancel out in the count.
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registers ALU requests, runs one EXEC cycle against an external combinational ALU,
// and queues {result, tag, err} responses in a result FIFO.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_opcode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [3:0]  req_tag,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_opcode,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_tag,
  output logic        rsp_err,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [31:0] a_q, b_q;
  logic [2:0]  op_q;
  logic [3:0]  tag_q;
  logic        err_q;

  logic        handshake;
  logic        fifo_push;
  logic        fifo_empty;
  logic        fifo_full;
  fifo_entry_t push_entry;
  fifo_entry_t head_entry;

  assign handshake = req_valid && req_ready;

  // Space is guaranteed at handshake since only EXEC pushes and it follows IDLE.
  assign req_ready = (state_q == StIdle) && !fifo_full;
  assign busy      = (state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    fifo_push = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          state_d = StExec;
        end
      end
      StExec: begin
        fifo_push = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_NONE;
      tag_q <= '0;
      err_q <= 1'b0;
    end else if (handshake) begin
      a_q   <= req_a;
      b_q   <= req_b;
      op_q  <= op_supported(req_opcode) ? req_opcode : OP_NONE;
      tag_q <= req_tag;
      err_q <= !op_supported(req_opcode);
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;

  always_comb begin
    push_entry        = '0;
    push_entry.result = err_q ? 32'h0 : alu_result;
    push_entry.tag    = tag_q;
    push_entry.err    = err_q;
  end

  alu_result_fifo #(
    .Depth   (FIFO_DEPTH),
    .entry_t (fifo_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (rsp_ready),
    .head      (head_entry),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign rsp_valid  = !fifo_empty;
  assign rsp_result = head_entry.result;
  assign rsp_tag    = head_entry.tag;
  assign rsp_err    = head_entry.err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed cases plus randomized traffic.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_opcode = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_tag = '0;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  fifo_entry_t exp_q[$];
  fifo_entry_t mon_e;
  bit rand_done = 1'b0;

  alu_op_sequencer #(
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Combinational ALU driven by the sequencer's registered operands.
  always_comb begin
    alu_result = 32'h0;
    case (alu_opcode)
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = (alu_a > alu_b) ? 32'd1 : 32'd0;
      3'b011:  alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
      default: alu_result = 32'h0;
    endcase
  end

  function automatic fifo_entry_t model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [3:0] tag);
    fifo_entry_t e;
    e.tag = tag;
    e.err = 1'b0;
    if (op == 3'b001)      e.result = a - b;
    else if (op == 3'b010) e.result = (a > b) ? 32'd1 : 32'd0;
    else if (op == 3'b011) e.result = (a < b) ? 32'd1 : 32'd0;
    else begin
      e.result = 32'h0;
      e.err    = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Holds a request until accepted; returns #1 after the handshake edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    bit hs = 1'b0;
    int budget = 0;
    req_valid  = 1'b1;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
    req_tag    = tag;
    while (!hs && budget < 200) begin
      @(negedge clk);
      hs = req_ready;
      @(posedge clk);
      budget++;
    end
    #1 req_valid = 1'b0;
    if (hs) begin
      exp_q.push_back(model(op, a, b, tag));
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: got no handshake, expected one for tag %h", tag);
    end
  endtask

  task automatic drain();
    int budget = 0;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: compares every popped head against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got tag %h, expected no response", rsp_tag);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_result", rsp_result, mon_e.result);
        check("rsp_tag", 32'(rsp_tag), 32'(mon_e.tag));
        check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_rst", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic sub with latency check.
    issue(3'b001, 32'd5, 32'd3, 4'h1);
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check("exec_alu_a", alu_a, 32'd5);
    check("exec_alu_b", alu_b, 32'd3);
    check("exec_alu_opcode", 32'(alu_opcode), 32'd1);
    @(posedge clk);
    #1;
    check("lat_rsp_valid", 32'(rsp_valid), 32'd1);
    check("lat_rsp_result", rsp_result, 32'd2);
    check("lat_busy", 32'(busy), 32'd0);
    drain();
    check("hold_alu_a", alu_a, 32'd5);
    check("hold_alu_opcode", 32'(alu_opcode), 32'd1);

    // Directed arithmetic/compare cases.
    rsp_ready = 1'b1;
    issue(3'b001, 32'd0, 32'd1, 4'h2);
    issue(3'b010, 32'd7, 32'd2, 4'h3);
    issue(3'b011, 32'd7, 32'd2, 4'h4);
    drain();

    // Unsupported opcode.
    issue(3'b111, 32'd9, 32'd9, 4'hF);
    check("bad_alu_opcode", 32'(alu_opcode), 32'd0);
    drain();

    // Fill the FIFO; the fifth request must stall until a pop.
    for (int i = 0; i < 4; i++) issue(3'b001, $urandom, $urandom, 4'(i));
    @(posedge clk);
    #1;
    req_valid  = 1'b1;
    req_opcode = 3'b010;
    req_a      = 32'd100;
    req_b      = 32'd50;
    req_tag    = 4'h4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    issue(3'b010, 32'd100, 32'd50, 4'h4);
    drain();

    // Push and pop on the same edge at count 1, across pointer wrap.
    issue(3'b001, 32'd20, 32'd1, 4'h0);
    @(posedge clk);
    #1;
    for (int k = 1; k <= 6; k++) begin
      issue(3'b001, $urandom, $urandom, 4'(k));
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      check("pushpop_valid", 32'(rsp_valid), 32'd1);
      check("pushpop_head_tag", 32'(rsp_tag), 32'(k));
    end
    drain();

    // Randomized traffic with random backpressure.
    fork
      begin
        for (int n = 0; n < 80; n++) begin
          issue(3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                4'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    // Reset during EXEC discards the in-flight request.
    issue(3'b001, 32'd11, 32'd4, 4'h7);
    void'(exp_q.pop_back());
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_alu_a", alu_a, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("abort_ready", 32'(req_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1 check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
